// File: rtl/i2s_stream_codec_if.sv
// I2S playback serializer and capture deserializer in the ac_bclk domain.
// Optional internal test tone: define AUDIO_TEST_TONE_EN.
module i2s_stream_codec_if #(
  parameter int SAMPLE_W   = 32,
  parameter int PKT_FRAMES = 16,
  parameter int CNT_W      = 16,
  parameter int TONE_HALF  = 64
) (
  input  logic                  ac_bclk,
  input  logic                  axis_aresetn,
  input  logic                  ac_pblrc,
  output logic                  ac_pbdat,
  input  logic                  ac_reclrc,
  input  logic                  ac_recdat,
  input  logic                  enable,
  input  logic [1:0]            word_length,
  input  logic                  test_mode,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [2*SAMPLE_W-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [2*SAMPLE_W-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [CNT_W-1:0]      underrun_cnt,
  output logic [CNT_W-1:0]      overrun_cnt
);

  localparam int SW = SAMPLE_W;
  localparam logic [5:0] SWL = 6'(SW);
  localparam logic [15:0] PKT_LAST = 16'(PKT_FRAMES - 1);

  typedef logic [SW-1:0] smp_t;

  function automatic logic [5:0] wl_decode(
    input logic [1:0] c
  );
    logic [5:0] w;
    case (c)
      2'b00:   w = 6'd16;
      2'b01:   w = 6'd20;
      2'b10:   w = 6'd24;
      default: w = 6'd32;
    endcase
    if (w > SWL) w = SWL;
    return w;
  endfunction

  // Left-align the low w bits so the shifter emits them MSB first.
  function automatic smp_t pb_align(
    input smp_t       s,
    input logic [5:0] w
  );
    return s << (SWL - w);
  endfunction

  // Sign-extend from bit w-1 to the full container.
  function automatic smp_t sext(
    input smp_t       s,
    input logic [5:0] w
  );
    logic [5:0] sh;
    sh = SWL - w;
    return smp_t'($signed(s << sh) >>> sh);
  endfunction

  logic       pblrc_q;
  logic       pb_edge;
  logic       pb_fs;
  logic [5:0] pb_wl;
  logic [5:0] pb_wl_q;
  smp_t       pb_sr;
  smp_t       pb_right_q;
  smp_t       pb_left_n;
  smp_t       pb_right_n;
  logic       tone_on;
  smp_t       tone_smp;

  assign pb_edge = ac_pblrc != pblrc_q;
  assign pb_fs   = pblrc_q & ~ac_pblrc;
  assign pb_wl   = pb_fs ? wl_decode(word_length) : pb_wl_q;

`ifdef AUDIO_TEST_TONE_EN
  localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  logic [TW-1:0] tone_cnt;
  logic          tone_hi;

  assign tone_on  = test_mode;
  assign tone_smp = tone_hi ? smp_t'(16'h1FFF) : '0;

  // Square-wave phase: toggles every TONE_HALF played frames.
  always_ff @(posedge ac_bclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      tone_cnt <= '0;
      tone_hi  <= 1'b1;
    end else if (pb_fs && enable && tone_on) begin
      if (tone_cnt == TW'(TONE_HALF - 1)) begin
        tone_cnt <= '0;
        tone_hi  <= ~tone_hi;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_tm;

  assign tone_on   = 1'b0;
  assign tone_smp  = '0;
  assign unused_tm = test_mode ^ (TONE_HALF == 0);
`endif

  assign s_axis_tready = axis_aresetn & pb_fs & enable
                       & ~tone_on & s_axis_tvalid;

  // Playback source for the frame starting this cycle.
  always_comb begin
    pb_left_n  = '0;
    pb_right_n = '0;
    if (tone_on) begin
      pb_left_n  = tone_smp;
      pb_right_n = tone_smp;
    end else if (s_axis_tvalid) begin
      pb_left_n  = s_axis_tdata[2*SW-1:SW];
      pb_right_n = s_axis_tdata[SW-1:0];
    end
  end

  // Playback framing, shifter load/shift and underrun count.
  always_ff @(posedge ac_bclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      pblrc_q      <= 1'b1;
      pb_wl_q      <= 6'd16;
      pb_sr        <= '0;
      pb_right_q   <= '0;
      underrun_cnt <= '0;
    end else begin
      pblrc_q <= ac_pblrc;
      if (pb_fs) begin
        pb_wl_q <= pb_wl;
        if (enable) begin
          pb_right_q <= pb_right_n;
          pb_sr      <= pb_align(pb_left_n, pb_wl);
          if (!tone_on && !s_axis_tvalid &&
              underrun_cnt != '1)
            underrun_cnt <= underrun_cnt + 1'b1;
        end else begin
          pb_right_q <= '0;
          pb_sr      <= '0;
        end
      end else if (pb_edge) begin
        pb_sr <= pb_align(pb_right_q, pb_wl_q);
      end else begin
        pb_sr <= {pb_sr[SW-2:0], 1'b0};
      end
    end
  end

  // Launch serial data on the falling edge for the codec.
  always_ff @(negedge ac_bclk or negedge axis_aresetn) begin
    if (!axis_aresetn) ac_pbdat <= 1'b0;
    else               ac_pbdat <= enable & pb_sr[SW-1];
  end

  logic       reclrc_q;
  logic       rc_edge;
  logic       rc_fs;
  logic       rc_busy;
  logic       rc_chan;
  logic       rc_done;
  logic       rc_left_ok;
  logic       rc_rdy;
  logic [5:0] rc_cnt;
  logic [5:0] rc_wl_q;
  smp_t       rc_sr;
  smp_t       rc_sr_n;
  smp_t       rc_left_q;
  smp_t       rc_right_q;

  assign rc_edge = ac_reclrc != reclrc_q;
  assign rc_fs   = reclrc_q & ~ac_reclrc;
  assign rc_sr_n = {rc_sr[SW-2:0], ac_recdat};
  assign rc_done = rc_busy & (rc_cnt == rc_wl_q - 6'd1);

  // Capture deserializer; a truncated slot drops the frame.
  always_ff @(posedge ac_bclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      reclrc_q   <= 1'b1;
      rc_busy    <= 1'b0;
      rc_chan    <= 1'b0;
      rc_cnt     <= '0;
      rc_wl_q    <= 6'd16;
      rc_sr      <= '0;
      rc_left_q  <= '0;
      rc_right_q <= '0;
      rc_left_ok <= 1'b0;
      rc_rdy     <= 1'b0;
    end else begin
      reclrc_q <= ac_reclrc;
      rc_rdy   <= 1'b0;
      if (rc_busy) begin
        rc_sr  <= rc_sr_n;
        rc_cnt <= rc_cnt + 6'd1;
      end
      if (rc_done) begin
        rc_busy <= 1'b0;
        if (!rc_chan) begin
          rc_left_q  <= sext(rc_sr_n, rc_wl_q);
          rc_left_ok <= 1'b1;
        end else if (rc_left_ok) begin
          rc_right_q <= sext(rc_sr_n, rc_wl_q);
          rc_rdy     <= 1'b1;
          rc_left_ok <= 1'b0;
        end
      end
      if (rc_edge) begin
        rc_busy <= 1'b1;
        rc_cnt  <= '0;
        rc_chan <= ac_reclrc;
        if (rc_fs) begin
          rc_wl_q    <= wl_decode(word_length);
          rc_left_ok <= 1'b0;
        end else if (rc_busy && !rc_done) begin
          rc_left_ok <= 1'b0;
        end
      end
    end
  end

  logic [15:0] pkt_cnt;
  logic        pkt_last;

  assign pkt_last = pkt_cnt == PKT_LAST;

  // AXIS capture output register, packet count and overrun count.
  always_ff @(posedge ac_bclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      pkt_cnt       <= '0;
      overrun_cnt   <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready)
        m_axis_tvalid <= 1'b0;
      if (rc_rdy && enable) begin
        if (!m_axis_tvalid || m_axis_tready) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= {rc_left_q, rc_right_q};
          m_axis_tlast  <= pkt_last;
          pkt_cnt       <= pkt_last ? '0 : pkt_cnt + 16'd1;
        end else if (overrun_cnt != '1) begin
          overrun_cnt <= overrun_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_stream_codec_if.sv
// Bench for i2s_stream_codec_if: codec model plus
// playback/capture scoreboards.
module tb_i2s_stream_codec_if;

  localparam int PKT = 4;

  logic        ac_bclk = 1'b0;
  logic        axis_aresetn = 1'b0;
  logic        ac_pblrc = 1'b1;
  logic        ac_pbdat;
  logic        ac_reclrc = 1'b1;
  logic        ac_recdat = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  word_length = 2'b00;
  logic        test_mode = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic [15:0] underrun_cnt;
  logic [15:0] overrun_cnt;

  i2s_stream_codec_if #(
    .SAMPLE_W  (32),
    .PKT_FRAMES(PKT),
    .CNT_W     (16),
    .TONE_HALF (2)
  ) dut (
    .ac_bclk      (ac_bclk),
    .axis_aresetn (axis_aresetn),
    .ac_pblrc     (ac_pblrc),
    .ac_pbdat     (ac_pbdat),
    .ac_reclrc    (ac_reclrc),
    .ac_recdat    (ac_recdat),
    .enable       (enable),
    .word_length  (word_length),
    .test_mode    (test_mode),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .underrun_cnt (underrun_cnt),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 ac_bclk = ~ac_bclk;

  int n_run = 0;
  int n_fail = 0;
  int tr_pulses = 0;
  int pkt_m = 0;
  int n_last = 0;

  logic [63:0] cap_q[$];
  logic [63:0] pb_q[$];

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wmask(input int wl);
    if (wl >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << wl) - 32'd1;
  endfunction

  function automatic logic [31:0] slot(
    input logic [31:0] s,
    input int          wl
  );
    return (s & wmask(wl)) << (32 - wl);
  endfunction

  function automatic logic [31:0] sext(
    input logic [31:0] s,
    input int          wl
  );
    logic [31:0] v;
    v = s & wmask(wl);
    if (v[wl-1]) v = v | ~wmask(wl);
    return v;
  endfunction

  function automatic logic [63:0] pb_exp(
    input logic [63:0] d,
    input int          wl
  );
    return {slot(d[63:32], wl), slot(d[31:0], wl)};
  endfunction

  function automatic int wl_of(input logic [1:0] c);
    case (c)
      2'b00:   return 16;
      2'b01:   return 20;
      2'b10:   return 24;
      default: return 32;
    endcase
  endfunction

  // Sink side: pop the scoreboard on every handshake.
  always @(negedge ac_bclk) begin
    logic [63:0] e;
    #2;
    if (s_axis_tready) tr_pulses++;
    if (axis_aresetn && m_axis_tvalid && m_axis_tready) begin
      if (cap_q.size() == 0) begin
        chk("cap_unexp", cap_q.size(), 1);
      end else begin
        e = cap_q.pop_front();
        chk("cap_data", m_axis_tdata, e);
        chk("cap_last", m_axis_tlast, pkt_m == PKT - 1);
        pkt_m = (pkt_m == PKT - 1) ? 0 : pkt_m + 1;
      end
      if (m_axis_tlast) n_last++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge ac_bclk);
  endtask

  // One 64-bclk frame, 32-bit slots, I2S one-bit delay.
  task automatic run_frame(
    input logic [31:0] rl,
    input logic [31:0] rr,
    input int          wl,
    input logic        pbv,
    input logic [63:0] pbd,
    input logic        pop_ok,
    input logic [63:0] pexp,
    input logic        push_cap
  );
    logic [63:0] rs;
    logic [63:0] ps;
    logic [63:0] e;
    int          tr0;
    rs = {slot(rl, wl), slot(rr, wl)};
    ps = '0;
    if (push_cap)
      cap_q.push_back({sext(rl, wl), sext(rr, wl)});
    pb_q.push_back(pexp);
    tr0 = tr_pulses;
    s_axis_tvalid = pbv;
    s_axis_tdata  = pbd;
    for (int k = 0; k < 64; k++) begin
      @(negedge ac_bclk);
      ac_pblrc  = (k >= 32);
      ac_reclrc = (k >= 32);
      ac_recdat = (k == 0) ? 1'b0 : rs[64-k];
      @(posedge ac_bclk);
      #1;
      if (k == 0) s_axis_tvalid = 1'b0;
      else        ps[64-k] = ac_pbdat;
    end
    chk("pb_pop", tr_pulses - tr0, pop_ok);
    e = pb_q.pop_front();
    chk("pb_left", ps[63:32], e[63:32]);
    chk("pb_right", ps[31:0], e[31:0]);
  endtask

  task automatic part_frame(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge ac_bclk);
      ac_pblrc  = (k >= 32);
      ac_reclrc = (k >= 32);
      ac_recdat = 1'($urandom);
    end
  endtask

  task automatic do_reset();
    chk("cap_drain", cap_q.size(), 0);
    @(negedge ac_bclk);
    axis_aresetn = 1'b0;
    idle(3);
    cap_q.delete();
    pkt_m  = 0;
    n_last = 0;
    axis_aresetn = 1'b1;
    idle(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] d;
    logic [63:0] first;
    logic [31:0] l;
    logic [31:0] r;
    logic [15:0] ur0;
    logic [15:0] ov0;
    int          wl;

    idle(3);
    chk("rst_pbdat", ac_pbdat, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_under", underrun_cnt, 0);
    chk("rst_over", overrun_cnt, 0);
    axis_aresetn = 1'b1;
    enable = 1'b1;
    idle(4);

    word_length = 2'b00;
    run_frame(32'h1234, 32'hBEEF, 16, 1'b1,
              64'h0000A5A5_00005A5A, 1'b1,
              64'hA5A50000_5A5A0000, 1'b1);

    for (int i = 0; i < 3; i++)
      run_frame($urandom, $urandom, 16, 1'b0, '0,
                1'b0, '0, 1'b1);
    chk("under3", underrun_cnt, 3);

    word_length = 2'b10;
    d = {32'($urandom), 32'($urandom)};
    run_frame(32'h800001, 32'h7FFFFF, 24, 1'b1, d,
              1'b1, pb_exp(d, 24), 1'b1);

    ur0 = underrun_cnt;
    for (int i = 0; i < 6; i++) begin
      word_length = 2'(i % 3);
      wl = wl_of(word_length);
      d = {32'($urandom), 32'($urandom)};
      run_frame($urandom, $urandom, wl, 1'b1, d,
                1'b1, pb_exp(d, wl), 1'b1);
    end
    chk("under_hold", underrun_cnt, ur0);
    idle(4);

    enable = 1'b0;
    run_frame($urandom, $urandom, 16, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0, 1'b0);
    chk("dis_under", underrun_cnt, ur0);
    idle(4);
    enable = 1'b1;

    word_length = 2'b10;
    m_axis_tready = 1'b0;
    ov0 = overrun_cnt;
    first = '0;
    for (int i = 0; i < 4; i++) begin
      l = $urandom;
      r = $urandom;
      if (i == 0) first = {sext(l, 24), sext(r, 24)};
      d = {32'($urandom), 32'($urandom)};
      run_frame(l, r, 24, 1'b1, d, 1'b1,
                pb_exp(d, 24), i == 0);
    end
    idle(8);
    chk("ovr_cnt", overrun_cnt - ov0, 3);
    chk("ovr_valid", m_axis_tvalid, 1);
    chk("ovr_hold", m_axis_tdata, first);
    m_axis_tready = 1'b1;
    idle(4);
    chk("ovr_drain", m_axis_tvalid, 0);

    do_reset();
    chk("rst2_under", underrun_cnt, 0);
    chk("rst2_over", overrun_cnt, 0);
    word_length = 2'b00;
    for (int i = 0; i < 5; i++) begin
      d = {32'($urandom), 32'($urandom)};
      run_frame($urandom, $urandom, 16, 1'b1, d,
                1'b1, pb_exp(d, 16), 1'b1);
    end
    idle(8);
    chk("pkt_last1", n_last, 1);
    part_frame(40);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d = {32'($urandom), 32'($urandom)};
      run_frame($urandom, $urandom, 16, 1'b1, d,
                1'b1, pb_exp(d, 16), 1'b1);
    end
    idle(8);
    chk("pkt_last2", n_last, 1);

`ifdef AUDIO_TEST_TONE_EN
    do_reset();
    test_mode = 1'b1;
    word_length = 2'b00;
    for (int i = 0; i < 6; i++) begin
      l = ((i / 2) % 2 == 0) ? 32'h1FFF : 32'h0;
      d = {32'($urandom), 32'($urandom)};
      run_frame($urandom, $urandom, 16, 1'b1, d,
                1'b0, {slot(l, 16), slot(l, 16)}, 1'b1);
    end
    chk("tone_under", underrun_cnt, 0);
    test_mode = 1'b0;
    idle(8);
`endif

    idle(8);
    chk("sb_empty", cap_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
